// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates the fetch and load/store requesters onto the single memory port
module mem_port_arbiter #(
    parameter bit          FIXED_PRIO = 1'b0,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    input  logic        we0,
    input  logic        req1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    input  logic        we1,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mux_sel,
    output logic [1:0]  grant,
    output logic        done0,
    output logic        done1,
    output logic [31:0] rdata,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t      state, next_state;
    logic        last_grant, pick, any_req, timeout_hit;
    logic [15:0] cnt;
    always_comb begin
        any_req     = req0 | req1;
        pick        = (req0 & req1) ? (FIXED_PRIO ? 1'b0 : ~last_grant) : ~req0;
        timeout_hit = cnt == 16'(TIMEOUT - 1);
        next_state  = state == IDLE ? (any_req ? BUSY : IDLE) :
                      state == BUSY ? ((mem_ready | timeout_hit) ? DONE : BUSY) : IDLE;
    end
    assign mem_valid = state == BUSY;
    assign mem_addr  = mux_sel ? addr1 : addr0;
    assign mem_wdata = mux_sel ? wdata1 : wdata0;
    assign mem_we    = mem_valid & (mux_sel ? we1 : we0);
    assign done0     = (state == DONE) & ~mux_sel;
    assign done1     = (state == DONE) & mux_sel;
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mux_sel    <= 1'b0;
            grant      <= 2'b00;
            last_grant <= 1'b1;
            cnt        <= '0;
            rdata      <= '0;
            err        <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && any_req) begin
                mux_sel    <= pick;
                grant      <= {pick, ~pick};
                last_grant <= pick;
                cnt        <= '0;
            end
            if (state == BUSY) begin
                if (mem_ready) begin
                    rdata <= mem_rdata;
                    err   <= 1'b0;
                end else if (timeout_hit) begin
                    err <= 1'b1;
                end else begin
                    cnt <= cnt + 16'd1;
                end
            end
            if (state == DONE) grant <= 2'b00;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of the round-robin and fixed-priority arbiter variants
module tb_mem_port_arbiter;
    logic        clk = 1'b0, rst = 1'b0;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0, mem_ready = 1'b0;
    logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0, mem_rdata = '0;
    logic        a_valid, a_we, a_sel, a_d0, a_d1, a_err;
    logic        b_valid, b_we, b_sel, b_d0, b_d1, b_err;
    logic [1:0]  a_grant, b_grant;
    logic [31:0] a_addr, a_wdata, a_rdata, b_addr, b_wdata, b_rdata;
    logic        sel_fp = 1'b0;
    logic        o_valid, o_we, o_sel, o_err;
    logic [1:0]  o_grant, o_done;
    logic [31:0] o_addr, o_wdata, o_rdata;
    int          total = 0, passed = 0;

    typedef struct {
        logic [1:0]  done;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    mem_port_arbiter #(.FIXED_PRIO(1'b0), .TIMEOUT(4)) dut_rr (
        .clk(clk), .rst(rst), .req0(req0), .addr0(addr0), .wdata0(wdata0), .we0(we0),
        .req1(req1), .addr1(addr1), .wdata1(wdata1), .we1(we1),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_valid(a_valid), .mem_addr(a_addr),
        .mem_wdata(a_wdata), .mem_we(a_we), .mux_sel(a_sel), .grant(a_grant),
        .done0(a_d0), .done1(a_d1), .rdata(a_rdata), .err(a_err));

    mem_port_arbiter #(.FIXED_PRIO(1'b1), .TIMEOUT(4)) dut_fp (
        .clk(clk), .rst(rst), .req0(req0), .addr0(addr0), .wdata0(wdata0), .we0(we0),
        .req1(req1), .addr1(addr1), .wdata1(wdata1), .we1(we1),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_valid(b_valid), .mem_addr(b_addr),
        .mem_wdata(b_wdata), .mem_we(b_we), .mux_sel(b_sel), .grant(b_grant),
        .done0(b_d0), .done1(b_d1), .rdata(b_rdata), .err(b_err));

    always_comb begin
        o_valid = sel_fp ? b_valid : a_valid;
        o_we    = sel_fp ? b_we : a_we;
        o_sel   = sel_fp ? b_sel : a_sel;
        o_err   = sel_fp ? b_err : a_err;
        o_grant = sel_fp ? b_grant : a_grant;
        o_done  = sel_fp ? {b_d1, b_d0} : {a_d1, a_d0};
        o_addr  = sel_fp ? b_addr : a_addr;
        o_wdata = sel_fp ? b_wdata : a_wdata;
        o_rdata = sel_fp ? b_rdata : a_rdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic push(input logic who, input logic [31:0] rd, input logic e);
        exp_t x;
        x.done  = who ? 2'b10 : 2'b01;
        x.rdata = rd;
        x.err   = e;
        sb.push_back(x);
    endtask

    // Called in the cycle the DONE pulse is due; compares against the oldest expectation.
    task automatic expect_done(input string tag);
        exp_t x;
        chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            x = sb.pop_front();
            chk({tag, "_done"}, 32'(o_done), 32'(x.done));
            chk({tag, "_rdata"}, o_rdata, x.rdata);
            chk({tag, "_err"}, 32'(o_err), 32'(x.err));
            chk({tag, "_valid_low"}, 32'(o_valid), 32'd0);
        end
    endtask

    task automatic do_reset();
        {req0, req1, we0, we1, mem_ready} = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_grant", 32'(o_grant), 0);
        chk("rst_sel", 32'(o_sel), 0);
        chk("rst_we", 32'(o_we), 0);
        chk("rst_done", 32'(o_done), 0);
        chk("rst_rdata", o_rdata, 0);
        chk("rst_err", 32'(o_err), 0);

        // single read, ready on second BUSY cycle
        addr0 = 32'h0000_0040;
        req0  = 1'b1;
        push(1'b0, 32'hDEAD_BEEF, 1'b0);
        tick();
        chk("rd_valid1", 32'(o_valid), 1);
        chk("rd_sel", 32'(o_sel), 0);
        chk("rd_grant", 32'(o_grant), 32'b01);
        chk("rd_addr", o_addr, 32'h40);
        chk("rd_we", 32'(o_we), 0);
        chk("rd_nodone", 32'(o_done), 0);
        tick();
        chk("rd_valid2", 32'(o_valid), 1);
        mem_ready = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ready = 1'b0;
        req0      = 1'b0;
        expect_done("rd");
        tick();
        chk("rd_idle_done", 32'(o_done), 0);
        chk("rd_idle_grant", 32'(o_grant), 0);
        chk("rd_hold", o_rdata, 32'hDEAD_BEEF);

        // write by requester 1; memory leaves the last read word on its bus
        addr1  = 32'h100;
        wdata1 = 32'h1234_5678;
        we1    = 1'b1;
        req1   = 1'b1;
        push(1'b1, 32'hDEAD_BEEF, 1'b0);
        tick();
        chk("wr_sel", 32'(o_sel), 1);
        chk("wr_grant", 32'(o_grant), 32'b10);
        chk("wr_we", 32'(o_we), 1);
        chk("wr_addr", o_addr, 32'h100);
        chk("wr_wdata", o_wdata, 32'h1234_5678);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        req1      = 1'b0;
        expect_done("wr");
        chk("wr_we_done", 32'(o_we), 0);
        tick();
        we1 = 1'b0;
        chk("wr_we_idle", 32'(o_we), 0);

        // timeout with TIMEOUT=4: four BUSY cycles then DONE with err
        addr0 = 32'h80;
        req0  = 1'b1;
        push(1'b0, 32'hDEAD_BEEF, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("to_busy%0d", i), 32'(o_valid), 1);
        end
        tick();
        req0 = 1'b0;
        expect_done("to");
        tick();
        chk("to_idle_valid", 32'(o_valid), 0);
        chk("to_idle_grant", 32'(o_grant), 0);

        // round-robin tie after reset with immediate ready
        do_reset();
        addr0     = 32'h1000;
        addr1     = 32'h2000;
        req0      = 1'b1;
        req1      = 1'b1;
        mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push(1'(k % 2), 32'hA000_0000 + 32'(k), 1'b0);
            tick();
            chk($sformatf("rr%0d_sel", k), 32'(o_sel), 32'(k % 2));
            chk($sformatf("rr%0d_addr", k), o_addr, (k % 2) ? 32'h2000 : 32'h1000);
            mem_rdata = 32'hA000_0000 + 32'(k);
            tick();
            expect_done($sformatf("rr%0d", k));
            tick();
            chk($sformatf("rr%0d_idle", k), 32'(o_grant), 0);
        end

        // fixed priority: requester 0 keeps winning until it drops
        do_reset();
        sel_fp    = 1'b1;
        req0      = 1'b1;
        req1      = 1'b1;
        mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            push(1'b0, 32'hB000_0000 + 32'(k), 1'b0);
            tick();
            chk($sformatf("fp%0d_sel", k), 32'(o_sel), 0);
            mem_rdata = 32'hB000_0000 + 32'(k);
            tick();
            expect_done($sformatf("fp%0d", k));
            tick();
        end
        req0 = 1'b0;
        push(1'b1, 32'hB000_00FF, 1'b0);
        tick();
        chk("fp_r1_sel", 32'(o_sel), 1);
        mem_rdata = 32'hB000_00FF;
        tick();
        req1 = 1'b0;
        expect_done("fp_r1");
        tick();
        mem_ready = 1'b0;
        sel_fp    = 1'b0;

        // reset during the second BUSY cycle
        do_reset();
        req0 = 1'b1;
        tick();
        tick();
        chk("mr_busy", 32'(o_valid), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_valid", 32'(o_valid), 0);
        chk("mr_grant", 32'(o_grant), 0);
        chk("mr_done", 32'(o_done), 0);
        req1 = 1'b1;
        tick();
        chk("mr_tie_sel", 32'(o_sel), 0);
        chk("mr_tie_grant", 32'(o_grant), 32'b01);
        chk("mr_nodone", 32'(o_done), 0);
        push(1'b0, 32'h0BAD_F00D, 1'b0);
        mem_ready = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        tick();
        {req0, req1, mem_ready} = '0;
        expect_done("mr");
        tick();

        chk("sb_empty", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
